// File: rtl/execute_stage_pipe_if.sv
// ---------------------------------------------------------------------------
// execute_stage_pipe_if
//
// Purpose : bundles the request/response handshake and data bus of the
//           execute stage so that producer and consumer connect as one port.
//
// Signals : flush       - synchronous abort of in-flight and buffered work
//           in_valid    - request presented
//           in_ready    - request can be accepted this cycle
//           operand1/2  - XLEN-bit source operands
//           alu_op      - OP_W-bit operation code
//           in_rd       - RD_W-bit destination tag, carried through unchanged
//           out_valid   - result register holds a valid result
//           out_ready   - consumer takes the result this cycle
//           alu_result  - registered XLEN-bit result
//           out_rd      - tag of the result
//           out_illegal - result came from an undefined alu_op
//           busy        - multi-cycle multiply in progress
//
// Modports: master - the side issuing requests and consuming results
//           slave  - the execute stage itself
// ---------------------------------------------------------------------------
interface execute_stage_pipe_if #(
  parameter int XLEN = 32,
  parameter int OP_W = 7,
  parameter int RD_W = 5
);

  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] operand1;
  logic [XLEN-1:0] operand2;
  logic [OP_W-1:0] alu_op;
  logic [RD_W-1:0] in_rd;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] alu_result;
  logic [RD_W-1:0] out_rd;
  logic            out_illegal;
  logic            busy;

  modport master (
    output flush, in_valid, operand1, operand2, alu_op, in_rd, out_ready,
    input  in_ready, out_valid, alu_result, out_rd, out_illegal, busy
  );

  modport slave (
    input  flush, in_valid, operand1, operand2, alu_op, in_rd, out_ready,
    output in_ready, out_valid, alu_result, out_rd, out_illegal, busy
  );

endinterface

// File: rtl/execute_stage_pipe.sv
// ---------------------------------------------------------------------------
// execute_stage_pipe
//
// Purpose : pipelined execute stage with a one-entry result register.
//           ADD/SUB/logic/shift/compare opcodes and undefined opcodes
//           complete with a latency of one cycle; MUL and MULHU run an
//           XLEN-cycle shift-add multiplier and complete XLEN+1 cycles after
//           acceptance.
//
// Ports   : clk   - single clock, all state changes on its rising edge
//           rst_n - synchronous active-low reset
//           bus   - execute_stage_pipe_if.slave carrying flush, the request
//                   handshake (in_valid/in_ready, operand1, operand2, alu_op,
//                   in_rd), the result handshake (out_valid/out_ready,
//                   alu_result, out_rd, out_illegal) and busy
// ---------------------------------------------------------------------------
module execute_stage_pipe #(
  parameter int XLEN = 32,
  parameter int OP_W = 7,
  parameter int RD_W = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  execute_stage_pipe_if.slave   bus
);

  localparam int SH_W = $clog2(XLEN);
  localparam int W2   = 2 * XLEN;

  localparam logic [OP_W-1:0] OP_ADD   = OP_W'(8'h00);
  localparam logic [OP_W-1:0] OP_SUB   = OP_W'(8'h01);
  localparam logic [OP_W-1:0] OP_AND   = OP_W'(8'h02);
  localparam logic [OP_W-1:0] OP_OR    = OP_W'(8'h03);
  localparam logic [OP_W-1:0] OP_XOR   = OP_W'(8'h04);
  localparam logic [OP_W-1:0] OP_SLL   = OP_W'(8'h05);
  localparam logic [OP_W-1:0] OP_SRL   = OP_W'(8'h06);
  localparam logic [OP_W-1:0] OP_SRA   = OP_W'(8'h07);
  localparam logic [OP_W-1:0] OP_SLT   = OP_W'(8'h08);
  localparam logic [OP_W-1:0] OP_SLTU  = OP_W'(8'h09);
  localparam logic [OP_W-1:0] OP_MUL   = OP_W'(8'h0A);
  localparam logic [OP_W-1:0] OP_MULHU = OP_W'(8'h0B);

  typedef enum logic {
    IDLE,
    MUL
  } state_t;

  state_t state, state_next;

  logic            res_valid;
  logic [XLEN-1:0] res_data;
  logic [RD_W-1:0] res_rd;
  logic            res_ill;

  logic [SH_W-1:0] count;
  logic [W2-1:0]   acc;
  logic [W2-1:0]   mcand;
  logic [XLEN-1:0] mplier;
  logic            mul_hi;
  logic [RD_W-1:0] mul_rd;

  logic            in_ready;
  logic            accept;
  logic            handoff;
  logic            is_mul_op;
  logic            mul_done;
  logic [W2-1:0]   acc_next;
  logic [SH_W-1:0] shamt;
  logic [XLEN-1:0] alu_value;
  logic            alu_ill;

  // The single result register may be refilled in the same cycle it drains,
  // which is what allows one result per cycle while the consumer keeps up.
  assign in_ready  = rst_n && !bus.flush && (state == IDLE) &&
                     (!res_valid || bus.out_ready);
  assign accept    = bus.in_valid && in_ready;
  assign handoff   = res_valid && bus.out_ready;
  assign is_mul_op = (bus.alu_op == OP_MUL) || (bus.alu_op == OP_MULHU);
  assign mul_done  = (state == MUL) && (count == '0);
  assign shamt     = bus.operand2[SH_W-1:0];

  // One shift-add step: add the shifted multiplicand when the current
  // multiplier bit is set. The last step's sum feeds the result register
  // directly so no extra cycle is spent after the counter reaches zero.
  assign acc_next  = acc + (mplier[0] ? mcand : '0);

  // Single-cycle ALU. Undefined opcodes yield zero and flag out_illegal;
  // the multiply opcodes are handled by the sequential datapath instead.
  always_comb begin
    alu_value = '0;
    alu_ill   = 1'b0;
    case (bus.alu_op)
      OP_ADD:   alu_value = bus.operand1 + bus.operand2;
      OP_SUB:   alu_value = bus.operand1 - bus.operand2;
      OP_AND:   alu_value = bus.operand1 & bus.operand2;
      OP_OR:    alu_value = bus.operand1 | bus.operand2;
      OP_XOR:   alu_value = bus.operand1 ^ bus.operand2;
      OP_SLL:   alu_value = bus.operand1 << shamt;
      OP_SRL:   alu_value = bus.operand1 >> shamt;
      OP_SRA:   alu_value = $signed(bus.operand1) >>> shamt;
      OP_SLT:   alu_value = {{(XLEN-1){1'b0}},
                             $signed(bus.operand1) < $signed(bus.operand2)};
      OP_SLTU:  alu_value = {{(XLEN-1){1'b0}}, bus.operand1 < bus.operand2};
      OP_MUL:   alu_value = '0;
      OP_MULHU: alu_value = '0;
      default:  alu_ill   = 1'b1;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state: flush always returns to IDLE, a multiply leaves IDLE on
  // acceptance and comes back once the counter has run down to zero.
  always_comb begin
    state_next = state;
    if (bus.flush) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    if (accept && is_mul_op) state_next = MUL;
        MUL:     if (count == '0) state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // Multiplier datapath. Operands and tag are captured at acceptance so the
  // requester is free to change its inputs while the multiply runs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count  <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      mul_hi <= 1'b0;
      mul_rd <= '0;
    end else if (bus.flush) begin
      count  <= '0;
    end else if (accept && is_mul_op) begin
      count  <= SH_W'(XLEN - 1);
      acc    <= '0;
      mcand  <= {{XLEN{1'b0}}, bus.operand1};
      mplier <= bus.operand2;
      mul_hi <= (bus.alu_op == OP_MULHU);
      mul_rd <= bus.in_rd;
    end else if (state == MUL) begin
      acc    <= acc_next;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      if (count != '0) begin
        count <= count - 1'b1;
      end
    end
  end

  // Result register. Loads win over a simultaneous handoff so a draining
  // entry is replaced rather than lost; flush discards whatever is held.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      res_valid <= 1'b0;
      res_data  <= '0;
      res_rd    <= '0;
      res_ill   <= 1'b0;
    end else if (bus.flush) begin
      res_valid <= 1'b0;
    end else if (accept && !is_mul_op) begin
      res_valid <= 1'b1;
      res_data  <= alu_value;
      res_rd    <= bus.in_rd;
      res_ill   <= alu_ill;
    end else if (mul_done) begin
      res_valid <= 1'b1;
      res_data  <= mul_hi ? acc_next[W2-1:XLEN] : acc_next[XLEN-1:0];
      res_rd    <= mul_rd;
      res_ill   <= 1'b0;
    end else if (handoff) begin
      res_valid <= 1'b0;
    end
  end

  assign bus.in_ready    = in_ready;
  assign bus.out_valid   = res_valid;
  assign bus.alu_result  = res_data;
  assign bus.out_rd      = res_rd;
  assign bus.out_illegal = res_ill;
  assign bus.busy        = (state == MUL);

endmodule

// File: tb/tb_execute_stage_pipe.sv
// ---------------------------------------------------------------------------
// tb_execute_stage_pipe
//
// Purpose : self-checking bench for execute_stage_pipe. A cycle monitor keeps
//           a queue of expected results, each tagged with the cycle at which
//           it must become visible, and compares handshake and data outputs
//           against it every cycle. Directed sequences exercise wrap-around,
//           shifts, compares, multiplies, back-pressure, flush and reset;
//           a randomized phase follows.
// ---------------------------------------------------------------------------
module tb_execute_stage_pipe;

  localparam int XLEN = 32;
  localparam int OP_W = 7;
  localparam int RD_W = 5;

  localparam logic [6:0] ADD   = 7'h00;
  localparam logic [6:0] SRA   = 7'h07;
  localparam logic [6:0] SLT   = 7'h08;
  localparam logic [6:0] SLTU  = 7'h09;
  localparam logic [6:0] MULOP = 7'h0A;
  localparam logic [6:0] MULHU = 7'h0B;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  execute_stage_pipe_if #(.XLEN(XLEN), .OP_W(OP_W), .RD_W(RD_W)) bus ();

  execute_stage_pipe #(.XLEN(XLEN), .OP_W(OP_W), .RD_W(RD_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    logic        ill;
    int          ready;
  } exp_t;

  exp_t exp_q[$];
  int   num_checks = 0;
  int   num_fails  = 0;
  int   cyc        = 0;
  logic prev_rst   = 1'b0;

  logic m_valid, m_inflight, m_in_ready;

  task automatic checkOutput(input string tag, input logic [63:0] got,
                             input logic [63:0] want);
    num_checks++;
    if (got !== want) begin
      num_fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
    end
  endtask

  // Reference ALU written from the opcode table with plain arithmetic.
  function automatic exp_t refModel(input logic [6:0] op, input logic [31:0] a,
                                    input logic [31:0] b, input logic [4:0] rd,
                                    input int ready);
    exp_t        e;
    logic [63:0] prod;
    int          sh;
    sh      = int'(b[4:0]);
    prod    = 64'(a) * 64'(b);
    e.rd    = rd;
    e.ill   = 1'b0;
    e.ready = ready;
    e.res   = 32'h0;
    case (op)
      7'h00: e.res = a + b;
      7'h01: e.res = a - b;
      7'h02: e.res = a & b;
      7'h03: e.res = a | b;
      7'h04: e.res = a ^ b;
      7'h05: e.res = a << sh;
      7'h06: e.res = a >> sh;
      7'h07: e.res = a[31] ? ~((~a) >> sh) : (a >> sh);
      7'h08: e.res = (a[31] != b[31]) ? {31'h0, a[31]} : {31'h0, a < b};
      7'h09: e.res = {31'h0, a < b};
      7'h0A: e.res = prod[31:0];
      7'h0B: e.res = prod[63:32];
      default: e.ill = 1'b1;
    endcase
    return e;
  endfunction

  // Cycle monitor: sampled mid-cycle, away from the rising edge.
  always @(negedge clk) begin
    if (prev_rst) begin
      checkOutput("rst_out_valid", 64'(bus.out_valid), 64'h0);
      checkOutput("rst_busy", 64'(bus.busy), 64'h0);
      checkOutput("rst_result", 64'(bus.alu_result), 64'h0);
      checkOutput("rst_rd", 64'(bus.out_rd), 64'h0);
      checkOutput("rst_illegal", 64'(bus.out_illegal), 64'h0);
    end
    if (!rst_n) begin
      checkOutput("rst_in_ready", 64'(bus.in_ready), 64'h0);
      exp_q.delete();
    end else begin
      m_inflight = (exp_q.size() > 0) && (exp_q[0].ready > cyc);
      m_valid    = (exp_q.size() > 0) && (exp_q[0].ready <= cyc);
      m_in_ready = !bus.flush && !m_inflight && (!m_valid || bus.out_ready);
      checkOutput("out_valid", 64'(bus.out_valid), 64'(m_valid));
      checkOutput("busy", 64'(bus.busy), 64'(m_inflight));
      checkOutput("in_ready", 64'(bus.in_ready), 64'(m_in_ready));
      if (m_valid) begin
        checkOutput("result", 64'(bus.alu_result), 64'(exp_q[0].res));
        checkOutput("out_rd", 64'(bus.out_rd), 64'(exp_q[0].rd));
        checkOutput("out_illegal", 64'(bus.out_illegal), 64'(exp_q[0].ill));
      end
      if (bus.flush) begin
        exp_q.delete();
      end else begin
        if (m_valid && bus.out_ready) exp_q.pop_front();
        if (bus.in_valid && m_in_ready) begin
          exp_q.push_back(refModel(bus.alu_op, bus.operand1, bus.operand2,
                                   bus.in_rd,
                                   (bus.alu_op == MULOP || bus.alu_op == MULHU)
                                     ? cyc + XLEN + 1 : cyc + 1));
        end
      end
    end
    prev_rst = !rst_n;
    cyc++;
  end

  // Present one request and hold it until it is accepted (bounded).
  // Returns just after the accepting edge.
  task automatic applyStimulus(input logic [6:0] op, input logic [31:0] a,
                               input logic [31:0] b, input logic [4:0] rd);
    logic got_it;
    got_it       = 1'b0;
    bus.in_valid = 1'b1;
    bus.alu_op   = op;
    bus.operand1 = a;
    bus.operand2 = b;
    bus.in_rd    = rd;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        got_it = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    checkOutput("accepted", 64'(got_it), 64'h1);
  endtask

  // Directed transaction with a known answer and latency (out_ready held 1).
  task automatic runOne(input string tag, input logic [6:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input logic [31:0] want,
                        input logic want_ill, input int want_lat);
    int lat;
    int busy_n;
    lat    = 0;
    busy_n = 0;
    applyStimulus(op, a, b, rd);
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (bus.busy) busy_n++;
      if (bus.out_valid) begin
        lat = k;
        break;
      end
    end
    checkOutput({tag, "_latency"}, 64'(lat), 64'(want_lat));
    checkOutput({tag, "_busy_cycles"}, 64'(busy_n), 64'(want_lat - 1));
    checkOutput({tag, "_result"}, 64'(bus.alu_result), 64'(want));
    checkOutput({tag, "_rd"}, 64'(bus.out_rd), 64'(rd));
    checkOutput({tag, "_illegal"}, 64'(bus.out_illegal), 64'(want_ill));
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] pickOperand();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'h1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    bus.flush     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.operand1  = '0;
    bus.operand2  = '0;
    bus.alu_op    = '0;
    bus.in_rd     = '0;
    bus.out_ready = 1'b1;
    rst_n         = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    $display("[TB] directed single-cycle operations");
    runOne("add_wrap", ADD, 32'hFFFF_FFFF, 32'h1, 5'd3, 32'h0, 1'b0, 1);
    runOne("sra", SRA, 32'h8000_0000, 32'h24, 5'd4, 32'hF800_0000, 1'b0, 1);
    runOne("slt", SLT, 32'hFFFF_FFFF, 32'h1, 5'd5, 32'h1, 1'b0, 1);
    runOne("sltu", SLTU, 32'hFFFF_FFFF, 32'h1, 5'd6, 32'h0, 1'b0, 1);
    runOne("illegal", 7'h7F, 32'h1234, 32'h5678, 5'd7, 32'h0, 1'b1, 1);

    $display("[TB] directed multiplies");
    runOne("mul", MULOP, 32'h0001_0003, 32'h0002_0005, 5'd8,
           32'h000B_000F, 1'b0, XLEN + 1);
    runOne("mulhu", MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd9,
           32'hFFFF_FFFE, 1'b0, XLEN + 1);

    $display("[TB] back-pressure with three ADD requests");
    bus.out_ready = 1'b0;
    applyStimulus(ADD, 32'd100, 32'd1, 5'd1);
    bus.in_valid = 1'b1;
    bus.alu_op   = ADD;
    bus.operand1 = 32'd200;
    bus.operand2 = 32'd2;
    bus.in_rd    = 5'd2;
    repeat (5) begin
      @(negedge clk);
      checkOutput("stall_in_ready", 64'(bus.in_ready), 64'h0);
      checkOutput("stall_valid", 64'(bus.out_valid), 64'h1);
      checkOutput("stall_result", 64'(bus.alu_result), 64'd101);
    end
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    applyStimulus(ADD, 32'd200, 32'd2, 5'd2);
    applyStimulus(ADD, 32'd300, 32'd3, 5'd3);
    repeat (3) @(posedge clk);
    #1;

    $display("[TB] flush during a multiply");
    applyStimulus(MULOP, 32'd7, 32'd9, 5'd4);
    bus.in_valid = 1'b1;
    bus.alu_op   = ADD;
    bus.operand1 = 32'd5;
    bus.operand2 = 32'd6;
    bus.in_rd    = 5'd5;
    repeat (9) @(posedge clk);
    #1;
    bus.flush = 1'b1;
    @(negedge clk);
    checkOutput("flush_in_ready", 64'(bus.in_ready), 64'h0);
    @(posedge clk);
    #1;
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    checkOutput("flush_busy", 64'(bus.busy), 64'h0);
    checkOutput("flush_out_valid", 64'(bus.out_valid), 64'h0);
    repeat (40) @(posedge clk);
    #1;
    runOne("after_flush", ADD, 32'd5, 32'd6, 5'd5, 32'd11, 1'b0, 1);

    $display("[TB] reset during a multiply");
    applyStimulus(MULOP, 32'd3, 32'd5, 5'd7);
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("midmul_rst_busy", 64'(bus.busy), 64'h0);
    checkOutput("midmul_rst_result", 64'(bus.alu_result), 64'h0);
    repeat (40) @(posedge clk);
    #1;

    $display("[TB] randomized traffic");
    for (int c = 0; c < 2000; c++) begin
      bus.in_valid  = ($urandom_range(0, 99) < 60);
      bus.alu_op    = ($urandom_range(0, 99) < 8) ? 7'($urandom_range(12, 127))
                                                  : 7'($urandom_range(0, 11));
      bus.operand1  = pickOperand();
      bus.operand2  = pickOperand();
      bus.in_rd     = 5'($urandom_range(0, 31));
      bus.out_ready = ($urandom_range(0, 99) < 70);
      bus.flush     = ($urandom_range(0, 199) == 0);
      @(posedge clk);
      #1;
    end

    bus.in_valid  = 1'b0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (exp_q.size() == 0) break;
      @(posedge clk);
      #1;
    end
    checkOutput("drain_empty", 64'(exp_q.size()), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             num_checks, num_fails);
    $finish;
  end

endmodule

// File: doc/execute_stage_pipe.md
EXECUTE_STAGE_PIPE -- requirements
Module: execute_stage_pipe

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, giving the operand and result width (legal values: 16, 32, 64).
REQ-002 The block SHALL have parameter OP_W, default 7, giving the alu_op width.
REQ-003 The block SHALL have parameter RD_W, default 5, giving the destination tag width.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: synchronous, active-low reset, sampled on the clk rising edge.
REQ-006 The block SHALL have port flush, input, 1 bit: synchronous abort of in-flight and buffered work.
REQ-007 The block SHALL have port in_valid, input, 1 bit: a request is presented.
REQ-008 The block SHALL have port in_ready, output, 1 bit: a request can be accepted this cycle.
REQ-009 The block SHALL have ports operand1 and operand2, input, XLEN bits each: source operands.
REQ-010 The block SHALL have port alu_op, input, OP_W bits: operation code.
REQ-011 The block SHALL have port in_rd, input, RD_W bits: destination tag, carried through unchanged.
REQ-012 The block SHALL have port out_valid, output, 1 bit: the result register holds a valid result.
REQ-013 The block SHALL have port out_ready, input, 1 bit: the consumer takes the result this cycle.
REQ-014 The block SHALL have port alu_result, output, XLEN bits: registered result.
REQ-015 The block SHALL have port out_rd, output, RD_W bits: tag of the result.
REQ-016 The block SHALL have port out_illegal, output, 1 bit: the result came from an undefined alu_op.
REQ-017 The block SHALL have port busy, output, 1 bit: a multi-cycle operation is in progress.

Function
REQ-018 Opcodes SHALL be: 0x00 ADD, 0x01 SUB, 0x02 AND, 0x03 OR, 0x04 XOR, 0x05 SLL, 0x06 SRL, 0x07 SRA, 0x08 SLT (signed, result 1/0), 0x09 SLTU, 0x0A MUL (low XLEN bits of product), 0x0B MULHU (high XLEN bits of unsigned product).
REQ-019 All other opcodes SHALL produce result 0 with out_illegal=1 and single-cycle latency; out_illegal SHALL be 0 for every defined opcode.
REQ-020 Arithmetic SHALL wrap modulo 2^XLEN; shift amount SHALL be operand2[log2(XLEN)-1:0], upper bits ignored.
REQ-021 A transfer SHALL occur when in_valid and in_ready are both high at a clk edge; an output handoff SHALL occur when out_valid and out_ready are both high.
REQ-022 FSM states SHALL be IDLE and MUL; reset and flush SHALL enter IDLE.
REQ-023 in_ready SHALL be 1 only in IDLE and when (out_valid=0 or out_ready=1), i.e. the one-entry result register is free or draining this cycle.
REQ-024 Opcodes 0x00-0x09 and illegal opcodes SHALL load the result register at the accepting edge, giving out_valid=1 in the next cycle (latency 1) and allowing back-to-back throughput of 1 per cycle while out_ready=1.
REQ-025 0x0A/0x0B SHALL enter MUL, with busy=1, and run a shift-add over exactly XLEN cycles on a 2*XLEN accumulator and a counter from XLEN-1 down to 0; on the last cycle the result register SHALL load and the FSM SHALL return to IDLE, so out_valid=1 exactly XLEN+1 cycles after acceptance.
REQ-026 Operands, opcode and tag SHALL be captured at acceptance; later input changes SHALL not affect an in-flight MUL.
REQ-027 While out_valid=1 and out_ready=0, alu_result, out_rd and out_illegal SHALL hold stable.
REQ-028 A handoff with no new result loading in the same edge SHALL clear out_valid; a handoff with a simultaneous load SHALL keep out_valid=1 with the new data.
REQ-029 flush=1 SHALL take priority over in_valid and MUL completion: at that edge out_valid=0, busy=0, FSM=IDLE, no request accepted; in_ready SHALL be 0 during the flush cycle.

Reset
REQ-030 While rst_n=0 at a clk edge, the block SHALL set out_valid=0, alu_result=0, out_rd=0, out_illegal=0, busy=0, FSM=IDLE and counter=0; reset SHALL override flush and all inputs.
REQ-031 in_ready SHALL be 0 while rst_n=0 and 1 in the first cycle after release.
REQ-032 Reset asserted mid-MUL SHALL abort the multiply with no output produced.

Verification
REQ-033 The bench SHALL cover ADD 0xFFFFFFFF+1, rd=3, out_ready=1 -> next cycle out_valid=1, alu_result=0, out_rd=3.
REQ-034 The bench SHALL cover SRA 0x80000000 by operand2=0x24 (shift 4) -> 0xF8000000; SLT 0xFFFFFFFF vs 1 -> 1; SLTU on the same operands -> 0.
REQ-035 The bench SHALL cover MUL 0x00010003 x 0x00020005 -> busy=1 for 32 cycles, in_ready=0, out_valid at cycle 33, result 0x000B000F; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE.
REQ-036 The bench SHALL cover a held out_ready=0 with three ADD requests -> one result held stable, in_ready=0, no loss or duplication once out_ready=1.
REQ-037 The bench SHALL cover flush at MUL cycle 10 with in_valid=1 -> busy=0, out_valid=0, nothing accepted; the next ADD completes normally.
REQ-038 The bench SHALL cover alu_op=0x7F -> alu_result=0, out_illegal=1; rst_n=0 mid-MUL -> all outputs 0 next cycle.
